// File: rtl/button_io_if.sv
// Core I/O bus as seen by the push-button peripheral.
//   bus_addr   core bus address (driven by master)
//   bus_wdata  core bus write data (driven by master)
//   bus_we     write strobe, one cycle per store (driven by master)
//   bus_rdata  read data for bus_addr (driven by slave)
interface button_io_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic [31:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_we,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_we,
        output bus_rdata
    );
endinterface

// File: rtl/button_io.sv
// Memory-mapped push-button peripheral.
// Synchronises and debounces the raw button inputs, latches press events into a
// write-1-to-clear pending register, counts presses, and raises an interrupt while
// any press is pending.
//
// Register window (offsets from BASE_ADDR):
//   +0 LEVEL  RO    debounced button state
//   +4 PEND   RW1C  latched press events
//   +8 COUNT  RW    16-bit press counter, any write clears it
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   btns       raw asynchronous button inputs, 1 = pressed
//   bus        core I/O bus (slave side); bus_rdata is 0 outside the window
//   btn_level  debounced button state
//   btn_irq    high while any pending bit is set
module button_io #(
    parameter logic [31:0] BASE_ADDR       = 32'h0001_0100,
    parameter int unsigned NBTN            = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btns,
    button_io_if.slave      bus,
    output logic [NBTN-1:0] btn_level,
    output logic            btn_irq
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [31:0] ADDR_LEVEL = BASE_ADDR;
    localparam logic [31:0] ADDR_PEND  = BASE_ADDR + 32'd4;
    localparam logic [31:0] ADDR_COUNT = BASE_ADDR + 32'd8;

    // Two-flop synchroniser; only sync2_q is used downstream.
    logic [NBTN-1:0]  sync1_q;
    logic [NBTN-1:0]  sync2_q;

    logic [NBTN-1:0]  stable_q;
    logic [NBTN-1:0]  stable_d;
    logic [CNT_W-1:0] cnt_q [NBTN];
    logic [CNT_W-1:0] cnt_d [NBTN];

    logic [NBTN-1:0]  pending_q;
    logic [NBTN-1:0]  pending_d;
    logic [15:0]      press_cnt_q;
    logic [15:0]      press_cnt_d;

    logic [NBTN-1:0]  rise;
    logic [15:0]      rise_cnt;
    logic [NBTN-1:0]  clr_mask;

    logic             sel_level;
    logic             sel_pend;
    logic             sel_count;
    logic             pend_we;
    logic             count_we;

    // ------------------------------------------------------------------
    // Address decode: full 32-bit compare, so misaligned offsets miss.
    // ------------------------------------------------------------------
    always_comb begin
        sel_level = (bus.bus_addr == ADDR_LEVEL);
        sel_pend  = (bus.bus_addr == ADDR_PEND);
        sel_count = (bus.bus_addr == ADDR_COUNT);
        pend_we   = bus.bus_we & sel_pend;
        count_we  = bus.bus_we & sel_count;
    end

    // ------------------------------------------------------------------
    // Debounce: each button has its own counter. A change on sync2_q is
    // accepted only after it has differed from stable_q for
    // DEBOUNCE_CYCLES consecutive cycles; any return to the stable value
    // restarts the count.
    // ------------------------------------------------------------------
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < int'(NBTN); i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Press events fire on the edge where the debounced level goes 0->1.
    always_comb begin
        rise     = stable_d & ~stable_q;
        rise_cnt = '0;
        for (int i = 0; i < int'(NBTN); i++) begin
            rise_cnt = rise_cnt + 16'(rise[i]);
        end
    end

    // ------------------------------------------------------------------
    // Pending and press counter. A new press beats a same-cycle W1C of
    // that bit, and a same-cycle COUNT write leaves only this edge's
    // presses in the counter.
    // ------------------------------------------------------------------
    always_comb begin
        clr_mask    = pend_we ? bus.bus_wdata[NBTN-1:0] : '0;
        pending_d   = (pending_q & ~clr_mask) | rise;
        press_cnt_d = (count_we ? 16'h0000 : press_cnt_q) + rise_cnt;
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            cnt_q       <= '{default: '0};
            pending_q   <= '0;
            press_cnt_q <= '0;
        end else begin
            sync1_q     <= btns;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux: combinational, shows pre-edge register values.
    // ------------------------------------------------------------------
    always_comb begin
        bus.bus_rdata = '0;
        if (sel_level) begin
            bus.bus_rdata = 32'(stable_q);
        end else if (sel_pend) begin
            bus.bus_rdata = 32'(pending_q);
        end else if (sel_count) begin
            bus.bus_rdata = {16'h0000, press_cnt_q};
        end
    end

    assign btn_level = stable_q;
    assign btn_irq   = |pending_q;

endmodule

// File: tb/tb_button_io.sv
// Directed bench for button_io with DEBOUNCE_CYCLES=4. Stimulus pushes expected
// values onto a scoreboard and pulses a strobe; a monitor pops and compares.
module tb_button_io;

    localparam logic [31:0] BASE = 32'h0001_0100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] btns;
    logic [4:0] btn_level;
    logic       btn_irq;

    button_io_if bus_if ();

    button_io #(
        .BASE_ADDR      (BASE),
        .NBTN           (5),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btns     (btns),
        .bus      (bus_if),
        .btn_level(btn_level),
        .btn_irq  (btn_irq)
    );

    always #10 clk = ~clk;

    typedef enum int {KRd, KLvl, KIrq} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic strobe = 1'b0;

    // Monitor: one scoreboard entry per strobe.
    always @(posedge strobe) begin
        exp_t        e;
        logic [31:0] act;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got strobe, required a queued expectation");
        end else begin
            e = sb.pop_front();
            case (e.kind)
                KRd:     act = bus_if.bus_rdata;
                KLvl:    act = 32'(btn_level);
                default: act = 32'(btn_irq);
            endcase
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h required %h", e.name, act, e.exp);
            end
        end
    end

    task automatic push_chk(input kind_e k, input logic [31:0] exp, input string name);
        exp_t e;
        e.kind = k;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
        #1 strobe = 1'b1;
        #1 strobe = 1'b0;
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string name);
        bus_if.bus_addr = BASE + off;
        push_chk(KRd, exp, name);
    endtask

    task automatic lvl(input logic [31:0] exp, input string name);
        push_chk(KLvl, exp, name);
    endtask

    task automatic irq(input logic [31:0] exp, input string name);
        push_chk(KIrq, exp, name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        bus_if.bus_addr  = BASE + off;
        bus_if.bus_wdata = data;
        bus_if.bus_we    = 1'b1;
        tick(1);
        bus_if.bus_we    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        btns             = 5'h1F;
        bus_if.bus_addr  = 32'h0;
        bus_if.bus_wdata = 32'h0;
        bus_if.bus_we    = 1'b0;

        // 1. Reset with all buttons held, then release.
        tick(3);
        lvl(32'h0, "rst_level");
        irq(32'h0, "rst_irq");
        rd(32'd0, 32'h0, "rst_rd_level");
        rd(32'd4, 32'h0, "rst_rd_pend");
        rd(32'd8, 32'h0, "rst_rd_count");
        rst = 1'b1;
        tick(5);
        lvl(32'h0, "t1_level_edge5");
        tick(1);
        lvl(32'h1F, "t1_level_edge6");
        irq(32'h1, "t1_irq");
        rd(32'd0, 32'h1F, "t1_rd_level");
        rd(32'd4, 32'h1F, "t1_rd_pend");
        rd(32'd8, 32'h5, "t1_rd_count");
        wr(32'd4, 32'h1F);
        wr(32'd8, 32'h1234);
        rd(32'd4, 32'h0, "t1_pend_cleared");
        rd(32'd8, 32'h0, "t1_count_cleared");
        irq(32'h0, "t1_irq_cleared");
        btns = 5'h00;
        tick(6);
        lvl(32'h0, "t1_release_level");
        rd(32'd4, 32'h0, "t1_release_pend");
        rd(32'd8, 32'h0, "t1_release_count");

        // 2. Three-cycle glitch on button 0 is rejected.
        btns = 5'h01;
        tick(3);
        btns = 5'h00;
        lvl(32'h0, "t2_level_mid");
        tick(8);
        lvl(32'h0, "t2_level");
        rd(32'd4, 32'h0, "t2_pend");
        rd(32'd8, 32'h0, "t2_count");
        irq(32'h0, "t2_irq");

        // 3. Press button 2, clear it via W1C.
        btns = 5'h04;
        tick(6);
        lvl(32'h4, "t3_level");
        rd(32'd4, 32'h4, "t3_pend");
        rd(32'd8, 32'h1, "t3_count");
        irq(32'h1, "t3_irq");
        wr(32'd4, 32'h4);
        rd(32'd4, 32'h0, "t3_pend_cleared");
        irq(32'h0, "t3_irq_cleared");
        rd(32'd8, 32'h1, "t3_count_kept");
        btns = 5'h00;
        tick(6);
        lvl(32'h0, "t3_release");

        // 4. W1C of bit 1 on the edge its press lands: set wins.
        btns = 5'h02;
        tick(5);
        wr(32'd4, 32'h2);
        rd(32'd4, 32'h2, "t4_pend_set_wins");
        irq(32'h1, "t4_irq");
        lvl(32'h2, "t4_level");
        rd(32'd8, 32'h2, "t4_count");
        wr(32'd4, 32'h2);
        rd(32'd4, 32'h0, "t4_pend_cleared");
        btns = 5'h00;
        tick(6);

        // 5. Counter wrap, then COUNT write on a press edge.
        force dut.press_cnt_q = 16'hFFFF;
        #1;
        release dut.press_cnt_q;
        rd(32'd8, 32'hFFFF, "t5_preload");
        btns = 5'h01;
        tick(6);
        rd(32'd8, 32'h0, "t5_wrap");
        rd(32'd4, 32'h1, "t5_pend");
        wr(32'd4, 32'h1);
        btns = 5'h00;
        tick(6);
        btns = 5'h08;
        tick(5);
        wr(32'd8, 32'hABCD);
        rd(32'd8, 32'h1, "t5_count_write_on_press");
        rd(32'd4, 32'h8, "t5_pend8");
        lvl(32'h8, "t5_level8");
        wr(32'd4, 32'h8);
        btns = 5'h00;
        tick(6);

        // 6. Reset mid-debounce discards the partial count.
        btns = 5'h01;
        tick(4);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        lvl(32'h0, "t6_after_rst");
        tick(5);
        lvl(32'h0, "t6_edge5");
        tick(1);
        lvl(32'h1, "t6_edge6");
        rd(32'd8, 32'h1, "t6_count");
        rd(32'd4, 32'h1, "t6_pend");
        rd(32'd12, 32'h0, "t6_unmapped_plus12");
        rd(32'd2, 32'h0, "t6_misaligned");
        rd(32'hFFFF_FFFC, 32'h0, "t6_below_base");
        wr(32'd0, 32'h0);
        wr(32'd12, 32'hFFFF_FFFF);
        lvl(32'h1, "t6_level_write_ignored");
        rd(32'd0, 32'h1, "t6_rd_level");
        rd(32'd4, 32'h1, "t6_pend_unchanged");
        rd(32'd8, 32'h1, "t6_count_unchanged");

        tick(2);
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
